line_window_buffer: RTL
=======================

// Module: line_window_buffer
// PURPOSE
//  Downstream of pixelcontroller. Takes 20-pixel grayscale batches, 8 b per pixel, handed over by a valid/ready handshake.
//  Keeps the two previous image rows in line RAMs and emits one 3x3 neighbourhood per incoming pixel to the Sobel/edge core.
//  Pixels are raster order across batches. A batch may straddle a row boundary.
// PARAMETERS
//  MAX_WIDTH  640  max row width in pixels (line RAM depth)
//  BATCH      20   pixels per load (matches pixelcontroller data_out)
//  PIX_W      8    bits per grayscale pixel
// PORTS
//  clk          in   1              system clock, rising edge
//  n_rst        in   1              async active-low reset
//  frame_start  in   1              1-cycle pulse: clear counters, begin new frame
//  row_width    in   10             pixels per row, 3..MAX_WIDTH, sampled at frame_start
//  num_rows     in   10             rows per frame, >=3, sampled at frame_start
//  load_valid   in   1              data_in holds a valid batch
//  data_in      in   BATCH*PIX_W    packed [BATCH-1:0][PIX_W-1:0]; element 0 = first pixel
//  load_ready   out  1              block can accept a batch this cycle
//  win_valid    out  1              window/win_row/win_col valid
//  win_ready    in   1              consumer accepts window this cycle
//  window       out  9*PIX_W        [2:0][2:0] pixels; [r][c], r0 = oldest row, c0 = leftmost column
//  win_row      out  10             centre row of window
//  win_col      out  10             centre column of window
//  frame_done   out  1              1-cycle pulse when last pixel of frame is consumed
// BEHAVIOUR
//  Reset (n_rst=0): state IDLE; load_ready=1; win_valid=0; window/win_row/win_col=0; frame_done=0.
//   Reset clears the row/col counters. Line RAM contents are don't-care.
//  FSM states
//   IDLE: load_ready=1. load_valid=1 latches data_in into batch reg, sets idx=0, and moves to SHIFT.
//   SHIFT: consumes pixel batch[idx] on any edge where (!win_valid || win_ready).
//    idx==BATCH-1 consumed -> IDLE.
//    Last frame pixel consumed -> DONE. Any remaining batch pixels are discarded.
//   DONE: load_ready=0 until frame_start.
//  Consume pixel p at (row,col):
//   - Read A=ramOld[col], B=ramMid[col] (row-2, row-1).
//   - Shift window left one column; load new right column {A,B,p}.
//   - Write p into ramOld[col], read-before-write in the same cycle.
//   - col++. At col==row_width-1, next col=0, row++, and ramOld/ramMid roles swap (1-bit select).
//  Window emission
//   - Registered. win_valid goes high the cycle after consuming a pixel with row>=2 and col>=2.
//   - win_row=row-1, win_col=col-1 of that pixel.
//   - Held stable while win_valid && !win_ready. Cleared on accept unless a new window is produced the same edge.
//  Throughput and latency
//   - 1 pixel/cycle with no stall. First window 1 cycle after its pixel is consumed.
//   - Batch turnaround: BATCH+1 cycles, since IDLE costs 1 cycle.
//  frame_done: asserted the cycle after the (num_rows-1, row_width-1) pixel is consumed, together with its final window.
//  frame_start has priority over everything, in any state:
//   - next state IDLE; row=col=0; RAM select=0; pending batch discarded
//   - win_valid=0 next cycle; row_width/num_rows latched
//  No windows for the 1-pixel border. Per frame: (num_rows-2)*(row_width-2) windows.
//  load_valid while load_ready=0 is ignored; the upstream must hold it.
//  Before the first frame_start, the geometry regs are reset to 0 and the block stays in IDLE.
//   - A batch loaded in this condition is consumed without producing windows.
// STRUCTURE
//  Package edge_pkg:
//   - pixel_t = logic[7:0]
//   - window_t = pixel_t [2:0][2:0]
//   - BATCH_PIX = 20
//   - lwb_state_t enum {IDLE, SHIFT, DONE}
//  Sub-module line_ram (MAX_WIDTH x PIX_W, one read + one write port, read-before-write)
//   - Instantiated twice; the role swap is by the select bit, not by copying data.
//  Top: FSM, batch register, idx/row/col counters, 3x3 shift register, output regs (~250 lines).
// TESTING
//  1 Reset mid-SHIFT (n_rst low at idx=7) -> immediately load_ready=1, win_valid=0, frame_done=0.
//  2 frame_start, row_width=40, num_rows=4, stream pixel k = k%256 in 8 batches, win_ready=1
//    -> 76 windows.
//    -> first window win_row=1, win_col=1 = {{0,1,2},{40,41,42},{80,81,82}}.
//    -> last window win_row=2, win_col=38.
//    -> frame_done pulses once; load_ready=0 afterwards.
//  3 Same stream, win_ready held 0 for 5 cycles at the first window -> window and coords stable.
//    No pixel consumed; idx frozen. Resumes with no loss or duplication (sequence compare).
//  4 row_width=30: batch 2 straddles row 0/1 (pixels 20..39)
//    -> col wraps 29->0 within the batch.
//    -> row 1 windows absent; first window at pixel 62 (row 2, col 2).
//  5 frame_start asserted during SHIFT of batch 3
//    -> win_valid=0 next cycle, batch dropped.
//    -> a new frame from k=0 reproduces scenario-2 windows exactly.
//  6 Back-to-back load_valid held high
//    -> load_ready pulses every 21 cycles; 160 pixels consumed in 168 cycles with win_ready=1.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared types and sizes for the line-window (3x3 neighbourhood) front end of the edge pipeline.
package edge_pkg;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned BATCH_PIX  = 20;
  localparam int unsigned LINE_DEPTH = 640;
  localparam int unsigned CNT_W      = 10;
  localparam int unsigned IDX_W      = 5;

  typedef logic [PIX_W-1:0]       pixel_t;
  typedef pixel_t [2:0][2:0]      window_t;
  typedef pixel_t [BATCH_PIX-1:0] batch_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } lwb_state_t;

  // Shift the window one column left and insert {top,mid,bot} as the new right column.
  function automatic window_t shift_in_column(input window_t w, input pixel_t top,
                                              input pixel_t mid, input pixel_t bot);
    window_t r;
    for (int i = 0; i < 3; i++) begin
      r[i][0] = w[i][1];
      r[i][1] = w[i][2];
    end
    r[0][2] = top;
    r[1][2] = mid;
    r[2][2] = bot;
    return r;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One row of pixels: asynchronous read, synchronous write, so a read and write to the
// same address in one cycle returns the old contents.
module line_ram #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_c_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/line_window_buffer.sv
// Turns a raster stream of 20-pixel batches into one 3x3 window per interior pixel,
// keeping the two previous rows in a pair of line RAMs whose roles swap each row.
module line_window_buffer
  import edge_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = LINE_DEPTH
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             frame_start,
  input  logic [CNT_W-1:0] row_width,
  input  logic [CNT_W-1:0] num_rows,
  input  logic             load_valid,
  input  batch_t           data_in,
  output logic             load_ready,
  output logic             win_valid,
  input  logic             win_ready,
  output window_t          window,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             frame_done
);

  localparam int unsigned RAM_AW = $clog2(MAX_WIDTH);

  lwb_state_t       state_q, state_d;
  batch_t           batch_q, batch_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
  logic [CNT_W-1:0] width_q, width_d, nrows_q, nrows_d;
  logic [CNT_W-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
  logic             sel_q, sel_d;
  window_t          win_q, win_d;
  logic             win_valid_q, win_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             load_ready_q, load_ready_d;

  pixel_t           rd0_c, rd1_c, old_c, mid_c, pix_c;
  logic             consume_c, row_end_c, last_pix_c, we0_c, we1_c;

  // sel_q=0: ram0 holds row-2 (old), ram1 holds row-1 (mid); swapped when sel_q=1.
  line_ram #(.DEPTH(MAX_WIDTH), .AW(RAM_AW), .DW(PIX_W)) u_ram0 (
    .clk       (clk),
    .we_i      (we0_c),
    .waddr_i   (RAM_AW'(col_q)),
    .wdata_i   (pix_c),
    .raddr_i   (RAM_AW'(col_q)),
    .rdata_c_o (rd0_c)
  );

  line_ram #(.DEPTH(MAX_WIDTH), .AW(RAM_AW), .DW(PIX_W)) u_ram1 (
    .clk       (clk),
    .we_i      (we1_c),
    .waddr_i   (RAM_AW'(col_q)),
    .wdata_i   (pix_c),
    .raddr_i   (RAM_AW'(col_q)),
    .rdata_c_o (rd1_c)
  );

  assign pix_c      = batch_q[idx_q];
  assign old_c      = sel_q ? rd1_c : rd0_c;
  assign mid_c      = sel_q ? rd0_c : rd1_c;
  assign consume_c  = (state_q == SHIFT) && (!win_valid_q || win_ready);
  assign row_end_c  = (col_q == width_q - CNT_W'(1));
  assign last_pix_c = row_end_c && (row_q == nrows_q - CNT_W'(1));
  assign we0_c      = consume_c && !frame_start && !sel_q;
  assign we1_c      = consume_c && !frame_start && sel_q;

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    batch_d      = batch_q;
    idx_d        = idx_q;
    row_d        = row_q;
    col_d        = col_q;
    width_d      = width_q;
    nrows_d      = nrows_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    sel_d        = sel_q;
    win_d        = win_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;
    load_ready_d = 1'b0;

    if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          batch_d = data_in;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (consume_c) begin
          win_d = shift_in_column(win_q, old_c, mid_c, pix_c);
          if ((row_q >= CNT_W'(2)) && (col_q >= CNT_W'(2))) begin
            win_valid_d = 1'b1;
            win_row_d   = row_q - CNT_W'(1);
            win_col_d   = col_q - CNT_W'(1);
          end
          idx_d = idx_q + IDX_W'(1);
          if (row_end_c) begin
            col_d = '0;
            row_d = row_q + CNT_W'(1);
            sel_d = ~sel_q;
          end else begin
            col_d = col_q + CNT_W'(1);
          end
          // Leftover pixels of the final batch are dropped once the frame completes.
          if (last_pix_c) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
          end else if (idx_q == IDX_W'(BATCH_PIX - 1)) begin
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (frame_start) begin
      state_d      = IDLE;
      row_d        = '0;
      col_d        = '0;
      sel_d        = 1'b0;
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      width_d      = row_width;
      nrows_d      = num_rows;
    end

    load_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      batch_q      <= '0;
      idx_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      width_q      <= '0;
      nrows_q      <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      sel_q        <= 1'b0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      batch_q      <= batch_d;
      idx_q        <= idx_d;
      row_q        <= row_d;
      col_q        <= col_d;
      width_q      <= width_d;
      nrows_q      <= nrows_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      sel_q        <= sel_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign load_ready = load_ready_q;
  assign win_valid  = win_valid_q;
  assign window     = win_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;

endmodule
